// File: rtl/dispatch_scheduler_if.sv
// Filter-FIFO pop/data bus plus the CGRA issue valid/ready bus of the dispatch scheduler.
// Latency: n/a (wires only).
// Backpressure: issue side is valid/ready; the FIFO side is pop-then-data-next-cycle.
interface dispatch_scheduler_if;
    // Thread-filter FIFO side
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_data_valid;
    logic [10:0] fifo_data_0;
    logic [10:0] fifo_data_1;
    logic [10:0] fifo_data_2;
    logic [10:0] fifo_data_3;

    // CGRA issue side
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_mask;
    logic [9:0]  issue_tid_0;
    logic [9:0]  issue_tid_1;
    logic [9:0]  issue_tid_2;
    logic [9:0]  issue_tid_3;

    // Scheduler view: pops the FIFOs, drives issue bundles
    modport master (
        output fifo_pop,
        input  fifo_empty,
        input  fifo_data_valid,
        input  fifo_data_0,
        input  fifo_data_1,
        input  fifo_data_2,
        input  fifo_data_3,
        output issue_valid,
        input  issue_ready,
        output issue_mask,
        output issue_tid_0,
        output issue_tid_1,
        output issue_tid_2,
        output issue_tid_3
    );

    // Environment view: FIFOs and the issue stage
    modport slave (
        input  fifo_pop,
        output fifo_empty,
        output fifo_data_valid,
        output fifo_data_0,
        output fifo_data_1,
        output fifo_data_2,
        output fifo_data_3,
        input  issue_valid,
        output issue_ready,
        input  issue_mask,
        input  issue_tid_0,
        input  issue_tid_1,
        input  issue_tid_2,
        input  issue_tid_3
    );
endinterface

// File: rtl/dispatch_scheduler.sv
// Thread-block dispatch: pops 4-lane bundles from the filter FIFOs into one bundle register and issues them.
// Latency: pop to issue_valid 2 cycles; one bundle per 2 cycles at full rate.
// Backpressure: issue_* held while !issue_ready; pops gated by an in-flight credit limit.
// Optional stall counters: define DISPATCH_SCHED_PERF_EN.
module dispatch_scheduler #(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          unrolling_factor,
    input  logic                gen_done,
    input  logic                retire,
    dispatch_scheduler_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    dispatched_cnt,
    output logic                retire_err
`ifdef DISPATCH_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_ready_cnt,
    output logic [31:0]         stall_credit_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Credit limit widened to the reservation sum width (inflight + pend + buf_valid)
    localparam logic [8:0] MAX_R = 9'(MAX_INFLIGHT);

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  lane_en;
    logic        pend;
    logic        buf_valid;
    logic [3:0]  buf_mask;
    logic [9:0]  buf_tid [4];
    logic [7:0]  inflight;
    logic [7:0]  inflight_nxt;
    logic [8:0]  reserved;

    logic [10:0] lane_dat [4];
    logic [3:0]  in_mask;
    logic [9:0]  in_tid [4];

    logic        start_acc;
    logic        fire;
    logic        pop;
    logic        load;
    logic        retire_ok;
    logic        retire_bad;

    function automatic logic [CNT_W-1:0] popcnt4(input logic [3:0] m);
        popcnt4 = CNT_W'(m[0]) + CNT_W'(m[1]) + CNT_W'(m[2]) + CNT_W'(m[3]);
    endfunction

    assign lane_dat[0] = bus.fifo_data_0;
    assign lane_dat[1] = bus.fifo_data_1;
    assign lane_dat[2] = bus.fifo_data_2;
    assign lane_dat[3] = bus.fifo_data_3;

    assign start_acc  = (state == S_IDLE) && start;
    assign fire       = buf_valid && bus.issue_ready;
    assign reserved   = {1'b0, inflight} + {8'd0, pend} + {8'd0, buf_valid};
    // A pop is only allowed when its bundle is guaranteed a credit and a free buffer slot
    assign pop        = (state == S_RUN) && !bus.fifo_empty && !pend &&
                        (!buf_valid || fire) && (reserved < MAX_R);
    // Returned pop data with no enabled valid lane is dropped without consuming a credit
    assign load       = pend && bus.fifo_data_valid && (in_mask != 4'd0);
    assign retire_ok  = retire && (inflight != 8'd0);
    assign retire_bad = retire && (inflight == 8'd0);

    // Per-lane mask against the latched lane enable; disabled/invalid lanes carry tid 0
    always_comb begin
        in_mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            in_tid[i]  = 10'd0;
            in_mask[i] = lane_dat[i][10] & lane_en[i];
            if (in_mask[i]) begin
                in_tid[i] = lane_dat[i][9:0];
            end
        end
    end

    // In-flight count after this cycle's fire and retire
    always_comb begin
        inflight_nxt = inflight;
        if (fire && !retire_ok) begin
            inflight_nxt = inflight + 8'd1;
        end else if (!fire && retire_ok) begin
            inflight_nxt = inflight - 8'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (gen_done && bus.fifo_empty && !pend && !buf_valid && !pop) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_nxt == 8'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lane enable latched at block start; uf=3 falls back to a single lane
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_en <= 4'b0000;
        end else if (start_acc) begin
            case (unrolling_factor)
                2'd1:    lane_en <= 4'b0011;
                2'd2:    lane_en <= 4'b1111;
                default: lane_en <= 4'b0001;
            endcase
        end
    end

    // Outstanding-pop flag: at most one pop in flight, data returns the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            pend <= pop;
        end
    end

    // Bundle register; contents cleared on issue so idle outputs read as zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_mask  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                buf_tid[i] <= 10'd0;
            end
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_mask  <= in_mask;
            for (int i = 0; i < 4; i++) begin
                buf_tid[i] <= in_tid[i];
            end
        end else if (fire) begin
            buf_valid <= 1'b0;
            buf_mask  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                buf_tid[i] <= 10'd0;
            end
        end
    end

    // In-flight credit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 8'd0;
        end else begin
            inflight <= inflight_nxt;
        end
    end

    // Dispatched-thread counter, restarted per block, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dispatched_cnt <= '0;
        end else if (start_acc) begin
            dispatched_cnt <= '0;
        end else if (fire) begin
            dispatched_cnt <= dispatched_cnt + popcnt4(buf_mask);
        end
    end

    // Sticky retire-underflow flag; a bad retire in the start cycle still sets it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_err <= 1'b0;
        end else if (retire_bad) begin
            retire_err <= 1'b1;
        end else if (start_acc) begin
            retire_err <= 1'b0;
        end
    end

`ifdef DISPATCH_SCHED_PERF_EN
    // Saturating stall counters: blocked by the issue stage, and blocked by credits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_ready_cnt  <= 32'd0;
            stall_credit_cnt <= 32'd0;
        end else if (start_acc) begin
            stall_ready_cnt  <= 32'd0;
            stall_credit_cnt <= 32'd0;
        end else begin
            if (buf_valid && !bus.issue_ready && (stall_ready_cnt != 32'hFFFF_FFFF)) begin
                stall_ready_cnt <= stall_ready_cnt + 32'd1;
            end
            if ((state == S_RUN) && !bus.fifo_empty && !pend && (reserved >= MAX_R) &&
                (stall_credit_cnt != 32'hFFFF_FFFF)) begin
                stall_credit_cnt <= stall_credit_cnt + 32'd1;
            end
        end
    end
`endif

    assign bus.fifo_pop    = pop;
    assign bus.issue_valid = buf_valid;
    assign bus.issue_mask  = buf_mask;
    assign bus.issue_tid_0 = buf_tid[0];
    assign bus.issue_tid_1 = buf_tid[1];
    assign bus.issue_tid_2 = buf_tid[2];
    assign bus.issue_tid_3 = buf_tid[3];
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: FIFO responder, random retire/ready, scoreboard of expected bundles.
// Latency: n/a.
// Backpressure: issue_ready driven directly or randomly per scenario.
module tb_dispatch_scheduler;
    localparam int MAXI = 3;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    uf = 2'd0;
    logic          gen_done = 1'b0;
    logic          retire = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] dispatched_cnt;
    logic          retire_err;
`ifdef DISPATCH_SCHED_PERF_EN
    logic [31:0]   stall_ready_cnt;
    logic [31:0]   stall_credit_cnt;
`endif

    dispatch_scheduler_if bus();

    dispatch_scheduler #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .unrolling_factor (uf),
        .gen_done         (gen_done),
        .retire           (retire),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .dispatched_cnt   (dispatched_cnt),
        .retire_err       (retire_err)
`ifdef DISPATCH_SCHED_PERF_EN
        ,
        .stall_ready_cnt  (stall_ready_cnt),
        .stall_credit_cnt (stall_credit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int now      = 0;

    logic [43:0] fq[$];     // bundles waiting in the filter FIFOs
    logic [43:0] exp_q[$];  // expected issues: {mask, tid3..tid0}
    int          rq[$];     // cycles at which a retire is due
    int          pop_t[$];

    int  fires, pops, done_cnt, exp_thr, first_iv;
    bit  auto_retire = 1'b0;
    int  retire_dly  = 1;
    bit  rdy_rand    = 1'b0;
    int  rdy_pct     = 100;

    logic        ob_valid, ob_pop;
    logic [3:0]  ob_mask, lf_mask;
    logic [39:0] ob_tids, lf_tids;

    // One clock: observe at negedge, then update inputs 1 time unit after posedge
    task automatic tick();
        logic [43:0] e;
        logic [43:0] d;
        @(negedge clk);
        ob_valid = bus.issue_valid;
        ob_pop   = bus.fifo_pop;
        ob_mask  = bus.issue_mask;
        ob_tids  = {bus.issue_tid_3, bus.issue_tid_2, bus.issue_tid_1, bus.issue_tid_0};
        if (done) done_cnt++;
        if (ob_pop) begin
            pops++;
            pop_t.push_back(now);
        end
        if (ob_valid && first_iv < 0) first_iv = now;
        if (ob_valid && bus.issue_ready) begin
            fires++;
            lf_mask = ob_mask;
            lf_tids = ob_tids;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL issue_unexpected: got bundle %h, expected no issue", {ob_mask, ob_tids});
            end else begin
                e = exp_q.pop_front();
                if ({ob_mask, ob_tids} !== e)
                    $display("FAIL issue_bundle: got %h expected %h", {ob_mask, ob_tids}, e);
                else
                    n_pass++;
            end
            if (auto_retire) rq.push_back(now + retire_dly);
        end
        @(posedge clk);
        #1;
        now++;
        if (ob_pop && fq.size() > 0) begin
            d = fq.pop_front();
            bus.fifo_data_valid = 1'b1;
        end else begin
            d = {12'($urandom()), $urandom()};
            bus.fifo_data_valid = 1'b0;
        end
        bus.fifo_data_0 = d[10:0];
        bus.fifo_data_1 = d[21:11];
        bus.fifo_data_2 = d[32:22];
        bus.fifo_data_3 = d[43:33];
        bus.fifo_empty  = (fq.size() == 0);
        retire = 1'b0;
        if (rq.size() > 0 && rq[0] <= now) begin
            void'(rq.pop_front());
            retire = 1'b1;
        end
        if (rdy_rand) bus.issue_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic begin_block();
        fires = 0; pops = 0; done_cnt = 0; exp_thr = 0; first_iv = -1;
        pop_t.delete(); exp_q.delete(); rq.delete();
    endtask

    // Queue a bundle in the FIFO model and derive what must be issued for it
    task automatic push_bundle(input logic [3:0] v, input logic [39:0] t);
        logic [3:0]  en, m;
        logic [43:0] d;
        logic [39:0] mt;
        case (uf)
            2'd1:    en = 4'b0011;
            2'd2:    en = 4'b1111;
            default: en = 4'b0001;
        endcase
        m = v & en;
        for (int i = 0; i < 4; i++) begin
            d[i*11 +: 11]  = {v[i], t[i*10 +: 10]};
            mt[i*10 +: 10] = m[i] ? t[i*10 +: 10] : 10'd0;
        end
        fq.push_back(d);
        bus.fifo_empty = 1'b0;
        if (m != 4'd0) begin
            exp_q.push_back({m, mt});
            exp_thr += $countones(m);
        end
    endtask

    task automatic start_block();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_block(input string nm, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (done_cnt == 0) $display("FAIL %s_done_timeout: got no done in %0d cycles, expected a done pulse", nm, budget);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (done_cnt !== 1) $display("FAIL %s_done_once: got %0d pulses expected 1", nm, done_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_busy_after: got %b expected 0", nm, busy);
        else n_pass++;
        n_checks++;
        if (dispatched_cnt !== CW'(exp_thr)) $display("FAIL %s_dispatched: got %0d expected %0d", nm, dispatched_cnt, exp_thr);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_missing_issues: got %0d left expected 0", nm, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.fifo_pop, bus.issue_valid, bus.issue_mask} !== 6'd0)
            $display("FAIL reset_issue: got %b expected 0", {bus.fifo_pop, bus.issue_valid, bus.issue_mask});
        else n_pass++;
        n_checks++;
        if ({bus.issue_tid_3, bus.issue_tid_2, bus.issue_tid_1, bus.issue_tid_0} !== 40'd0)
            $display("FAIL reset_tids: got %h expected 0", {bus.issue_tid_3, bus.issue_tid_2, bus.issue_tid_1, bus.issue_tid_0});
        else n_pass++;
        n_checks++;
        if ({busy, done, retire_err, dispatched_cnt} !== 19'd0)
            $display("FAIL reset_status: got %h expected 0", {busy, done, retire_err, dispatched_cnt});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_lane();
        begin_block();
        uf = 2'd0; auto_retire = 1'b1; retire_dly = 2; rdy_rand = 1'b0;
        bus.issue_ready = 1'b1; gen_done = 1'b1;
        for (int i = 5; i <= 7; i++) push_bundle({3'($urandom()), 1'b1}, {30'($urandom()), 10'(i)});
        start_block();
        finish_block("single", 200);
        n_checks++;
        if (fires !== 3) $display("FAIL single_fires: got %0d expected 3", fires);
        else n_pass++;
        n_checks++;
        if (dispatched_cnt !== 16'd3) $display("FAIL single_cnt: got %0d expected 3", dispatched_cnt);
        else n_pass++;
    endtask

    task automatic test_four_lane();
        begin_block();
        uf = 2'd2; auto_retire = 1'b1; retire_dly = 1; bus.issue_ready = 1'b1; gen_done = 1'b1;
        push_bundle(4'b1101, {10'd13, 10'd12, 10'd555, 10'd10});
        start_block();
        finish_block("four", 200);
        n_checks++;
        if (lf_mask !== 4'b1101) $display("FAIL four_mask: got %b expected 1101", lf_mask);
        else n_pass++;
        n_checks++;
        if (lf_tids[19:10] !== 10'd0) $display("FAIL four_tid1: got %0d expected 0", lf_tids[19:10]);
        else n_pass++;
        n_checks++;
        if (dispatched_cnt !== 16'd3) $display("FAIL four_cnt: got %0d expected 3", dispatched_cnt);
        else n_pass++;
    endtask

    task automatic test_credit_limit();
        begin_block();
        uf = 2'd2; auto_retire = 1'b0; bus.issue_ready = 1'b1; gen_done = 1'b1;
        for (int i = 0; i < MAXI + 2; i++) push_bundle(4'($urandom_range(1, 15)), {$urandom(), 8'($urandom())});
        start_block();
        for (int i = 0; i < 25; i++) tick();
        n_checks++;
        if (fires !== MAXI) $display("FAIL credit_fires: got %0d expected %0d", fires, MAXI);
        else n_pass++;
        n_checks++;
        if (pops !== MAXI || ob_pop !== 1'b0) $display("FAIL credit_pops: got %0d pop=%b expected %0d pop=0", pops, ob_pop, MAXI);
        else n_pass++;
        retire = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (pops !== MAXI + 1 || fires !== MAXI + 1)
            $display("FAIL credit_one_more: got pops %0d fires %0d expected %0d", pops, fires, MAXI + 1);
        else n_pass++;
        auto_retire = 1'b1; retire_dly = 1;
        for (int i = 0; i < MAXI; i++) rq.push_back(now + 1 + i);
        finish_block("credit", 200);
    endtask

    task automatic test_backpressure();
        logic [3:0]  m0;
        logic [39:0] t0;
        int          p0;
        begin_block();
        uf = 2'd2; auto_retire = 1'b1; retire_dly = 1; bus.issue_ready = 1'b0; gen_done = 1'b1;
        push_bundle(4'($urandom_range(1, 15)), {$urandom(), 8'($urandom())});
        push_bundle(4'($urandom_range(1, 15)), {$urandom(), 8'($urandom())});
        start_block();
        for (int i = 0; i < 20 && !ob_valid; i++) tick();
        n_checks++;
        if (ob_valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", ob_valid);
        else n_pass++;
        m0 = ob_mask; t0 = ob_tids; p0 = pops;
        n_checks++;
        if ({m0, t0} !== exp_q[0]) $display("FAIL bp_content: got %h expected %h", {m0, t0}, exp_q[0]);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({ob_valid, ob_mask, ob_tids} !== {1'b1, m0, t0} || pops !== p0)
                $display("FAIL bp_hold: got %h pops %0d expected %h pops %0d", {ob_valid, ob_mask, ob_tids}, pops, {1'b1, m0, t0}, p0);
            else n_pass++;
        end
        bus.issue_ready = 1'b1;
        tick();
        n_checks++;
        if (fires !== 1) $display("FAIL bp_release: got %0d fires expected 1", fires);
        else n_pass++;
        finish_block("bp", 200);
    endtask

    task automatic test_drop();
        begin_block();
        uf = 2'd1; auto_retire = 1'b1; retire_dly = 1; bus.issue_ready = 1'b1; gen_done = 1'b1;
        push_bundle(4'b0000, {$urandom(), 8'($urandom())});
        push_bundle(4'b1100, {$urandom(), 8'($urandom())});
        push_bundle(4'b1000, {$urandom(), 8'($urandom())});
        start_block();
        finish_block("drop", 200);
        n_checks++;
        if (fires !== 0 || pops !== 3) $display("FAIL drop_counts: got fires %0d pops %0d expected 0 and 3", fires, pops);
        else n_pass++;
        n_checks++;
        if (retire_err !== 1'b0) $display("FAIL drop_err: got %b expected 0", retire_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        begin_block();
        uf = 2'd2; auto_retire = 1'b1; retire_dly = 1; bus.issue_ready = 1'b1; gen_done = 1'b1;
        for (int i = 0; i < 4; i++) push_bundle(4'($urandom_range(1, 15)), {$urandom(), 8'($urandom())});
        start_block();
        finish_block("b2b", 200);
        n_checks++;
        if (pop_t.size() !== 4) $display("FAIL b2b_pops: got %0d expected 4", pop_t.size());
        else n_pass++;
        for (int i = 1; i < pop_t.size(); i++) begin
            n_checks++;
            if (pop_t[i] - pop_t[i-1] !== 2) $display("FAIL b2b_spacing: got %0d expected 2", pop_t[i] - pop_t[i-1]);
            else n_pass++;
        end
        n_checks++;
        if (pop_t.size() == 0 || first_iv - pop_t[0] !== 2)
            $display("FAIL b2b_latency: got %0d expected 2", (pop_t.size() == 0) ? -1 : first_iv - pop_t[0]);
        else n_pass++;
    endtask

    task automatic test_retire_err();
        retire = 1'b1;
        tick();
        n_checks++;
        if (retire_err !== 1'b1) $display("FAIL rerr_set: got %b expected 1", retire_err);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (retire_err !== 1'b1) $display("FAIL rerr_sticky: got %b expected 1", retire_err);
        else n_pass++;
        begin_block();
        gen_done = 1'b1;
        start_block();
        finish_block("empty", 50);
        n_checks++;
        if (retire_err !== 1'b0) $display("FAIL rerr_clear: got %b expected 0", retire_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        begin_block();
        uf = 2'd2; auto_retire = 1'b0; bus.issue_ready = 1'b1; gen_done = 1'b0;
        for (int i = 0; i < MAXI + 2; i++) push_bundle(4'($urandom_range(1, 15)), {$urandom(), 8'($urandom())});
        start_block();
        for (int i = 0; i < 40 && fires < MAXI; i++) tick();
        tick(); tick();
        n_checks++;
        if (fires !== MAXI || busy !== 1'b1) $display("FAIL midrst_setup: got fires %0d busy %b expected %0d 1", fires, busy, MAXI);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({busy, bus.fifo_pop, bus.issue_valid, bus.issue_mask, done, retire_err, dispatched_cnt} !== 25'd0)
            $display("FAIL midrst_outputs: got %h expected 0", {busy, bus.fifo_pop, bus.issue_valid, bus.issue_mask, done, retire_err, dispatched_cnt});
        else n_pass++;
        n_checks++;
        if ({bus.issue_tid_3, bus.issue_tid_2, bus.issue_tid_1, bus.issue_tid_0} !== 40'd0)
            $display("FAIL midrst_tids: got %h expected 0", {bus.issue_tid_3, bus.issue_tid_2, bus.issue_tid_1, bus.issue_tid_0});
        else n_pass++;
        rst_n = 1'b1;
        fq.delete(); exp_q.delete(); rq.delete();
        bus.fifo_empty = 1'b1; gen_done = 1'b0;
        tick();
        retire = 1'b1;
        tick();
        n_checks++;
        if (retire_err !== 1'b1) $display("FAIL midrst_retire_err: got %b expected 1", retire_err);
        else n_pass++;
    endtask

    task automatic test_random();
        int nb, gd;
        for (int b = 0; b < 6; b++) begin
            begin_block();
            uf = 2'($urandom_range(0, 3));
            rdy_rand = 1'b1; rdy_pct = $urandom_range(40, 100);
            auto_retire = 1'b1; retire_dly = $urandom_range(1, 5);
            gen_done = 1'b0;
            nb = $urandom_range(3, 10);
            for (int i = 0; i < nb; i++) push_bundle(4'($urandom()), {$urandom(), 8'($urandom())});
            start_block();
            gd = $urandom_range(0, 10);
            for (int i = 0; i < gd; i++) tick();
            gen_done = 1'b1;
            finish_block("rand", 800);
            n_checks++;
            if (retire_err !== 1'b0) $display("FAIL rand_err: got %b expected 0", retire_err);
            else n_pass++;
        end
        rdy_rand = 1'b0;
    endtask

    initial begin
        bus.fifo_empty = 1'b1; bus.fifo_data_valid = 1'b0; bus.issue_ready = 1'b0;
        bus.fifo_data_0 = '0; bus.fifo_data_1 = '0; bus.fifo_data_2 = '0; bus.fifo_data_3 = '0;
        begin_block();
        test_reset();
        test_single_lane();
        test_four_lane();
        test_credit_limit();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_retire_err();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
